// File: rtl/lift_pkg.sv
// Shared types and encodings for the SCAN lift controller.
package lift_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MOVE = 2'd1,
      DOOR = 2'd2
   } state_t;

   localparam logic [1:0] DIR_NONE = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DN   = 2'b10;

endpackage

// File: rtl/lift_timer.sv
// Loadable down-counter shared by the travel and door phases.
// done is high whenever the count has reached zero; a load always wins
// over a decrement, and the counter parks at zero when enabled there.
module lift_timer #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic             done
);

   logic [WIDTH-1:0] count;

   // Count down from the loaded value, holding at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/lift_scan_ctrl.sv
// Single-car lift controller with a latched request bitmap and SCAN
// scheduling: pending floors ahead are served before the car reverses.
module lift_scan_ctrl
   import lift_pkg::*;
#(
   parameter int N_FLOORS   = 8,
   parameter int FLOOR_W    = $clog2(N_FLOORS),
   parameter int TRAVEL_CYC = 4,
   parameter int DOOR_CYC   = 3
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_valid_i,
   input  logic [FLOOR_W-1:0]  req_floor_i,
   output logic [FLOOR_W-1:0]  cur_floor_o,
   output logic [1:0]          dir_o,
   output logic                moving_o,
   output logic                door_open_o,
   output logic                arrive_o,
   output logic [N_FLOORS-1:0] pending_o,
   output logic                err_o
);

   localparam int MAX_CYC = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
   localparam int TW      = $clog2(MAX_CYC + 1);

   // Timer reload values: the phase ends on the edge that sees zero.
   localparam logic [TW-1:0]      TRAVEL_LD   = TW'(TRAVEL_CYC - 1);
   localparam logic [TW-1:0]      DOOR_LD     = TW'(DOOR_CYC - 1);
   localparam logic [FLOOR_W:0]   FLOOR_LIMIT = (FLOOR_W + 1)'(N_FLOORS);
   localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(N_FLOORS - 1);

   state_t              state;
   logic [FLOOR_W-1:0]  cur_floor;
   logic [1:0]          dir;
   logic                moving;
   logic                door_open;
   logic                arrive;
   logic                err;
   logic [N_FLOORS-1:0] pending;

   logic [N_FLOORS-1:0] cur_onehot;
   logic [N_FLOORS-1:0] step_onehot;
   logic [N_FLOORS-1:0] req_onehot;
   logic [N_FLOORS-1:0] below_mask;
   logic [N_FLOORS-1:0] above_mask;
   logic [N_FLOORS-1:0] req_mask;
   logic [FLOOR_W-1:0]  step_floor;
   logic                in_range;
   logic                req_ok;
   logic                door_hit;
   logic                cur_pend;
   logic                step_pend;
   logic                any_above;
   logic                any_below;
   logic                go_up;

   logic                timer_load;
   logic                timer_en;
   logic [TW-1:0]       timer_val;
   logic                timer_done;

   // Floors above and below the car come from masking against the
   // one-hot position, so no per-floor comparators are needed.
   assign cur_onehot  = N_FLOORS'(1) << cur_floor;
   assign below_mask  = cur_onehot - N_FLOORS'(1);
   assign above_mask  = ~(below_mask | cur_onehot);
   assign any_above   = |(pending & above_mask);
   assign any_below   = |(pending & below_mask);
   assign cur_pend    = |(pending & cur_onehot);

   // The floor the car reaches next if it keeps travelling; the one-hot
   // form avoids indexing pending with a possibly out-of-range value.
   assign step_floor  = (dir == DIR_UP) ? (cur_floor + FLOOR_W'(1))
                                        : (cur_floor - FLOOR_W'(1));
   assign step_onehot = (dir == DIR_UP) ? (cur_onehot << 1) : (cur_onehot >> 1);
   assign step_pend   = |(pending & step_onehot);

   // Keep going the same way while work remains there; with no history
   // the car prefers up.
   assign go_up = ((dir == DIR_UP)   && any_above) ||
                  ((dir == DIR_DN)   && !any_below) ||
                  ((dir == DIR_NONE) && any_above);

   // A request for the floor whose door is open is absorbed rather than
   // latched, and keeps the door open longer.
   assign in_range   = ({1'b0, req_floor_i} < FLOOR_LIMIT);
   assign req_ok     = req_valid_i && in_range;
   assign door_hit   = req_ok && (state == DOOR) && (req_floor_i == cur_floor);
   assign req_onehot = N_FLOORS'(1) << req_floor_i;
   assign req_mask   = (req_ok && !door_hit) ? req_onehot : '0;

   // Timer control follows the same decisions the state machine makes,
   // reloading on every phase change and counting otherwise.
   always_comb begin
      timer_load = 1'b0;
      timer_en   = 1'b0;
      timer_val  = TRAVEL_LD;
      case (state)
         IDLE: begin
            if (cur_pend) begin
               timer_load = 1'b1;
               timer_val  = DOOR_LD;
            end else if (|pending) begin
               timer_load = 1'b1;
            end
         end
         MOVE: begin
            if (timer_done) begin
               timer_load = 1'b1;
               if (step_pend) begin
                  timer_val = DOOR_LD;
               end
            end else begin
               timer_en = 1'b1;
            end
         end
         DOOR: begin
            if (door_hit) begin
               timer_load = 1'b1;
               timer_val  = DOOR_LD;
            end else begin
               timer_en = 1'b1;
            end
         end
         default: begin
            timer_load = 1'b0;
         end
      endcase
   end

   lift_timer #(
      .WIDTH (TW)
   ) u_timer (
      .clk      (clk_i),
      .rst_n    (rst_i),
      .load     (timer_load),
      .load_val (timer_val),
      .en       (timer_en),
      .done     (timer_done)
   );

   // Main SCAN state machine with registered outputs and request latch.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state     <= IDLE;
         cur_floor <= '0;
         dir       <= DIR_NONE;
         moving    <= 1'b0;
         door_open <= 1'b0;
         arrive    <= 1'b0;
         err       <= 1'b0;
         pending   <= '0;
      end else begin
         arrive  <= 1'b0;
         err     <= req_valid_i && !in_range;
         pending <= pending | req_mask;
         case (state)
            IDLE: begin
               if (cur_pend) begin
                  pending   <= (pending | req_mask) & ~cur_onehot;
                  state     <= DOOR;
                  door_open <= 1'b1;
                  arrive    <= 1'b1;
               end else if (|pending) begin
                  state  <= MOVE;
                  moving <= 1'b1;
                  dir    <= go_up ? DIR_UP : DIR_DN;
               end
            end
            MOVE: begin
               if (timer_done) begin
                  cur_floor <= step_floor;
                  if (step_pend) begin
                     pending   <= (pending | req_mask) & ~step_onehot;
                     state     <= DOOR;
                     moving    <= 1'b0;
                     door_open <= 1'b1;
                     arrive    <= 1'b1;
                  end
               end
            end
            DOOR: begin
               if (!door_hit && timer_done) begin
                  state     <= IDLE;
                  door_open <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign cur_floor_o = cur_floor;
   assign dir_o       = dir;
   assign moving_o    = moving;
   assign door_open_o = door_open;
   assign arrive_o    = arrive;
   assign pending_o   = pending;
   assign err_o       = err;

   // Travel always has a request ahead, so the car never steps off either end.
   no_step_past_top: assert property (@(posedge clk_i) disable iff (!rst_i)
      (state == MOVE && timer_done && dir == DIR_UP) |-> (cur_floor != TOP_FLOOR));

   no_step_past_bottom: assert property (@(posedge clk_i) disable iff (!rst_i)
      (state == MOVE && timer_done && dir == DIR_DN) |-> (cur_floor != '0));

   floor_in_range: assert property (@(posedge clk_i) disable iff (!rst_i)
      (cur_floor <= TOP_FLOOR));

   move_door_exclusive: assert property (@(posedge clk_i) disable iff (!rst_i)
      !(moving && door_open));

endmodule

// File: tb/tb_lift_scan_ctrl.sv
// Scoreboard bench for lift_scan_ctrl: directed requests push expected
// arrivals (floor, direction, cycle, door length, remaining requests),
// and an independent monitor pops one entry on every arrive pulse.
module tb_lift_scan_ctrl;

   logic       clk;
   logic       rst_n;
   logic       req_valid;
   logic [2:0] req_floor;
   logic [2:0] cur_floor;
   logic [1:0] dir;
   logic       moving;
   logic       door_open;
   logic       arrive;
   logic [7:0] pending;
   logic       err;

   logic       req_valid6;
   logic [2:0] req_floor6;
   logic [2:0] cur_floor6;
   logic [1:0] dir6;
   logic       moving6;
   logic       door_open6;
   logic       arrive6;
   logic [5:0] pending6;
   logic       err6;

   int cyc      = 0;
   int asserts  = 0;
   int fails    = 0;
   int door_run = 0;
   int exp_door = 0;

   typedef struct {
      int floor;
      int dir;
      int cyc;
      int door;
      int pend;
   } exp_t;

   exp_t exp_q[$];

   lift_scan_ctrl #(
      .N_FLOORS   (8),
      .TRAVEL_CYC (4),
      .DOOR_CYC   (3)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_n),
      .req_valid_i (req_valid),
      .req_floor_i (req_floor),
      .cur_floor_o (cur_floor),
      .dir_o       (dir),
      .moving_o    (moving),
      .door_open_o (door_open),
      .arrive_o    (arrive),
      .pending_o   (pending),
      .err_o       (err)
   );

   lift_scan_ctrl #(
      .N_FLOORS   (6),
      .TRAVEL_CYC (4),
      .DOOR_CYC   (3)
   ) dut6 (
      .clk_i       (clk),
      .rst_i       (rst_n),
      .req_valid_i (req_valid6),
      .req_floor_i (req_floor6),
      .cur_floor_o (cur_floor6),
      .dir_o       (dir6),
      .moving_o    (moving6),
      .door_open_o (door_open6),
      .arrive_o    (arrive6),
      .pending_o   (pending6),
      .err_o       (err6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input int act, input int exp);
      asserts++;
      if (act != exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input int f, input int d, input int c, input int dr, input int p);
      exp_t e;
      e.floor = f;
      e.dir   = d;
      e.cyc   = c;
      e.door  = dr;
      e.pend  = p;
      exp_q.push_back(e);
   endtask

   // Caller sits on a negedge; the request is sampled at the next posedge
   // and stamp is the cycle count right after that edge.
   task automatic apply_stimulus(input int floor, output int stamp);
      req_valid = 1'b1;
      req_floor = 3'(floor);
      @(negedge clk);
      req_valid = 1'b0;
      stamp     = cyc;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: pops one expectation per arrive pulse and measures door length.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check_output("move_door_exclusive", int'(moving & door_open), 0);
            if (err) begin
               asserts++;
               fails++;
               $display("[TB] FAIL unexpected_err: got 1, expected 0 (cycle %0d)", cyc);
            end
            if (arrive) begin
               if (exp_q.size() == 0) begin
                  asserts++;
                  fails++;
                  $display("[TB] FAIL unexpected_arrive: got floor %0d, expected no arrival", cur_floor);
               end else begin
                  e = exp_q.pop_front();
                  check_output("arrive_floor",   int'(cur_floor), e.floor);
                  check_output("arrive_dir",     int'(dir),       e.dir);
                  check_output("arrive_cycle",   cyc,             e.cyc);
                  check_output("arrive_pending", int'(pending),   e.pend);
                  check_output("arrive_door",    int'(door_open), 1);
                  exp_door = e.door;
               end
            end
            if (door_open) begin
               door_run++;
            end else if (door_run != 0) begin
               check_output("door_length", door_run, exp_door);
               door_run = 0;
            end
         end else begin
            door_run = 0;
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios in sequence.
   initial begin
      int s;
      int t;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_floor  = '0;
      req_valid6 = 1'b0;
      req_floor6 = '0;
      wait_cycles(3);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] reset state");
      check_output("rst_cur_floor", int'(cur_floor), 0);
      check_output("rst_dir",       int'(dir),       0);
      check_output("rst_moving",    int'(moving),    0);
      check_output("rst_door",      int'(door_open), 0);
      check_output("rst_arrive",    int'(arrive),    0);
      check_output("rst_pending",   int'(pending),   0);
      check_output("rst_err",       int'(err),       0);

      $display("[TB] out-of-range request on 6-floor car");
      req_valid6 = 1'b1;
      req_floor6 = 3'd7;
      @(negedge clk);
      req_valid6 = 1'b0;
      check_output("err6_pulse",   int'(err6),       1);
      check_output("err6_pending", int'(pending6),   0);
      check_output("err6_moving",  int'(moving6),    0);
      check_output("err6_door",    int'(door_open6), 0);
      @(negedge clk);
      check_output("err6_clear",   int'(err6),       0);
      check_output("err6_idle",    int'(moving6),    0);

      $display("[TB] request at current floor 0");
      apply_stimulus(0, s);
      push_exp(0, 0, s + 1, 3, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_output("same_floor_no_motion", int'(moving), 0);
      end
      wait_cycles(2);

      $display("[TB] request floor 5 from floor 0");
      apply_stimulus(5, s);
      push_exp(5, 1, s + 21, 3, 0);
      @(negedge clk);
      check_output("move_entered", int'(moving), 1);
      check_output("move_dir_up",  int'(dir),    1);
      wait_cycles(3);
      check_output("floor_before_first_step", int'(cur_floor), 0);
      @(negedge clk);
      check_output("floor_first_step", int'(cur_floor), 1);
      wait_cycles(12);
      check_output("floor_fourth_step", int'(cur_floor), 4);
      wait_cycles(8);
      check_output("after5_pending", int'(pending),   0);
      check_output("after5_door",    int'(door_open), 0);
      check_output("after5_moving",  int'(moving),    0);

      $display("[TB] floor 5 down to floor 2");
      apply_stimulus(2, s);
      push_exp(2, 2, s + 13, 3, 0);
      wait_cycles(17);

      $display("[TB] up to 6 with requests 4 and 1 arriving en route");
      apply_stimulus(6, s);
      apply_stimulus(4, t);
      apply_stimulus(1, t);
      push_exp(4, 1, s + 9,  3, 8'h42);
      push_exp(6, 1, s + 21, 3, 8'h02);
      push_exp(1, 2, s + 45, 3, 0);
      check_output("scan_pending_latched", int'(pending), 8'h52);
      wait_cycles(48);
      check_output("scan_final_floor",   int'(cur_floor), 1);
      check_output("scan_final_dir",     int'(dir),       2);
      check_output("scan_final_pending", int'(pending),   0);

      $display("[TB] door restart at floor 3");
      apply_stimulus(3, s);
      push_exp(3, 1, s + 9, 4, 0);
      wait_cycles(9);
      apply_stimulus(3, t);
      check_output("restart_pending", int'(pending),   0);
      check_output("restart_door",    int'(door_open), 1);
      wait_cycles(5);

      $display("[TB] asynchronous reset mid-travel");
      apply_stimulus(7, s);
      wait_cycles(6);
      check_output("pre_reset_moving", int'(moving),    1);
      check_output("pre_reset_floor",  int'(cur_floor), 4);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("async_cur_floor", int'(cur_floor), 0);
      check_output("async_dir",       int'(dir),       0);
      check_output("async_moving",    int'(moving),    0);
      check_output("async_door",      int'(door_open), 0);
      check_output("async_arrive",    int'(arrive),    0);
      check_output("async_pending",   int'(pending),   0);
      check_output("async_err",       int'(err),       0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_cycles(3);
      check_output("post_reset_moving",  int'(moving),    0);
      check_output("post_reset_door",    int'(door_open), 0);
      check_output("post_reset_pending", int'(pending),   0);
      check_output("post_reset_floor",   int'(cur_floor), 0);

      check_output("scoreboard_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
